// File: rtl/ifft8_pkg.sv
// Shared types and constants for the 8-point serial IFFT: FSM states, data
// format and the conjugate twiddle table.
package ifft8_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_t;

  // Conjugate twiddles exp(+j*2*pi*m/8) in Q8.8, m = 0..3
  localparam logic signed [DATA_W-1:0] W0_RE = 16'sd256;
  localparam logic signed [DATA_W-1:0] W0_IM = 16'sd0;
  localparam logic signed [DATA_W-1:0] W1_RE = 16'sd181;
  localparam logic signed [DATA_W-1:0] W1_IM = 16'sd181;
  localparam logic signed [DATA_W-1:0] W2_RE = 16'sd0;
  localparam logic signed [DATA_W-1:0] W2_IM = 16'sd256;
  localparam logic signed [DATA_W-1:0] W3_RE = -16'sd181;
  localparam logic signed [DATA_W-1:0] W3_IM = 16'sd181;

  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

endpackage

// File: rtl/ifft8_bfly.sv
// Combinational radix-2 DIT butterfly: y0 = a + w*b, y1 = a - w*b, with an
// optional divide-by-two on both results.
module ifft8_bfly
  import ifft8_pkg::*;
#(
  parameter int SCALE = 1
) (
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  input  logic signed [DATA_W-1:0] w_re,
  input  logic signed [DATA_W-1:0] w_im,
  output logic signed [DATA_W-1:0] y0_re,
  output logic signed [DATA_W-1:0] y0_im,
  output logic signed [DATA_W-1:0] y1_re,
  output logic signed [DATA_W-1:0] y1_im
);

  logic signed [31:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [31:0] t_re_full, t_im_full;
  logic signed [DATA_W-1:0] t_re, t_im;
  logic signed [DATA_W:0] s_re, s_im, d_re, d_im;

  assign p_rr = b_re * w_re;
  assign p_ii = b_im * w_im;
  assign p_ri = b_re * w_im;
  assign p_ir = b_im * w_re;

  assign t_re_full = p_rr - p_ii;
  assign t_im_full = p_ri + p_ir;

  // Back to Q8.8 by truncation (floor), then keep the low 16 bits
  assign t_re = DATA_W'(t_re_full >>> FRAC_W);
  assign t_im = DATA_W'(t_im_full >>> FRAC_W);

  assign s_re = {a_re[DATA_W-1], a_re} + {t_re[DATA_W-1], t_re};
  assign s_im = {a_im[DATA_W-1], a_im} + {t_im[DATA_W-1], t_im};
  assign d_re = {a_re[DATA_W-1], a_re} - {t_re[DATA_W-1], t_re};
  assign d_im = {a_im[DATA_W-1], a_im} - {t_im[DATA_W-1], t_im};

  // Unscaled results wrap; scaled results keep the 17-bit sum's top 16 bits
  assign y0_re = (SCALE != 0) ? DATA_W'(s_re >>> 1) : DATA_W'(s_re);
  assign y0_im = (SCALE != 0) ? DATA_W'(s_im >>> 1) : DATA_W'(s_im);
  assign y1_re = (SCALE != 0) ? DATA_W'(d_re >>> 1) : DATA_W'(d_re);
  assign y1_im = (SCALE != 0) ? DATA_W'(d_im >>> 1) : DATA_W'(d_im);

endmodule

// File: rtl/ifft8_serial.sv
// 8-point serial IFFT: load eight bins, run twelve in-place butterflies
// through one shared butterfly, then stream eight time samples.
module ifft8_serial
  import ifft8_pkg::*;
#(
  parameter int SCALE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_real,
  input  logic signed [DATA_W-1:0] in_imag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_real,
  output logic signed [DATA_W-1:0] out_imag,
  output logic [2:0]               out_index,
  output logic                     out_last,
  output state_t                   state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid/data are held by the source until that edge, ready may be anything.

  state_t state, state_nxt;
  logic [2:0] ld_cnt;
  logic [3:0] bf_cnt;
  logic [2:0] out_cnt;

  logic signed [DATA_W-1:0] mem_re [8];
  logic signed [DATA_W-1:0] mem_im [8];

  logic       in_xfer, out_xfer;
  logic [1:0] stage, j, tw_idx;
  logic [2:0] top_addr, bot_addr;
  logic signed [DATA_W-1:0] w_re, w_im;
  logic signed [DATA_W-1:0] y0_re, y0_im, y1_re, y1_im;

  assign state_dbg = state;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && ld_cnt == 3'd7) state_nxt = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (bf_cnt == 4'd11) state_nxt = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready && out_cnt == 3'd7) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  // Butterfly j of stage s pairs addresses top and top + 2^s
  assign stage = bf_cnt[3:2];
  assign j     = bf_cnt[1:0];

  always_comb begin
    top_addr = {j, 1'b0};
    bot_addr = {j, 1'b1};
    tw_idx   = 2'd0;
    case (stage)
      2'd1: begin
        top_addr = {j[1], 1'b0, j[0]};
        bot_addr = {j[1], 1'b1, j[0]};
        tw_idx   = {j[0], 1'b0};
      end
      2'd2: begin
        top_addr = {1'b0, j};
        bot_addr = {1'b1, j};
        tw_idx   = j;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_re = W0_RE;
    w_im = W0_IM;
    case (tw_idx)
      2'd1: begin w_re = W1_RE; w_im = W1_IM; end
      2'd2: begin w_re = W2_RE; w_im = W2_IM; end
      2'd3: begin w_re = W3_RE; w_im = W3_IM; end
      default: ;
    endcase
  end

  ifft8_bfly #(.SCALE(SCALE)) u_bfly (
    .a_re  (mem_re[top_addr]),
    .a_im  (mem_im[top_addr]),
    .b_re  (mem_re[bot_addr]),
    .b_im  (mem_im[bot_addr]),
    .w_re  (w_re),
    .w_im  (w_im),
    .y0_re (y0_re),
    .y0_im (y0_im),
    .y1_re (y1_re),
    .y1_im (y1_im)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_LOAD;
      ld_cnt  <= 3'd0;
      bf_cnt  <= 4'd0;
      out_cnt <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        mem_re[i] <= '0;
        mem_im[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      case (state)
        ST_LOAD: begin
          if (in_xfer) begin
            mem_re[bitrev3(ld_cnt)] <= in_real;
            mem_im[bitrev3(ld_cnt)] <= in_imag;
            ld_cnt <= ld_cnt + 3'd1;
          end
        end
        ST_COMPUTE: begin
          mem_re[top_addr] <= y0_re;
          mem_im[top_addr] <= y0_im;
          mem_re[bot_addr] <= y1_re;
          mem_im[bot_addr] <= y1_im;
          bf_cnt <= (bf_cnt == 4'd11) ? 4'd0 : bf_cnt + 4'd1;
        end
        ST_OUTPUT: begin
          if (out_xfer) out_cnt <= out_cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs read straight from memory, so they hold while out_ready is low
  assign out_index = out_cnt;
  assign out_real  = out_valid ? mem_re[out_cnt] : '0;
  assign out_imag  = out_valid ? mem_im[out_cnt] : '0;
  assign out_last  = out_valid && (out_cnt == 3'd7);

endmodule

// File: tb/tb_ifft8_serial.sv
// Directed bench for ifft8_serial: hand-computed frames, backpressure, gapped
// input and mid-compute reset.
module tb_ifft8_serial;
  import ifft8_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [15:0] in_real = '0;
  logic signed [15:0] in_imag = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic signed [15:0] out_real, out_imag;
  logic [2:0] out_index;
  logic out_last;
  state_t state_dbg;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] frame_in [8];
  logic [31:0] exp_q [$];

  ifft8_serial #(.SCALE(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .out_index (out_index),
    .out_last  (out_last),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cx(input int re, input int im);
    return {re[15:0], im[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_frame();
    for (int k = 0; k < 8; k++) frame_in[k] = cx(0, 0);
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Drives frame_in; optionally idles in_valid between samples and checks
  // the first-output latency with in_ready low throughout
  task automatic send_frame(input bit gapped, input bit check_latency);
    logic [31:0] s;
    int cycles;
    for (int k = 0; k < 8; k++) begin
      if (gapped) begin
        in_valid = 1'b0;
        tick();
      end
      s = frame_in[k];
      in_valid = 1'b1;
      in_real = s[31:16];
      in_imag = s[15:0];
      check("in_ready_load", int'(in_ready), 1);
      tick();
    end
    in_valid = 1'b0;
    if (check_latency) begin
      cycles = 0;
      while (!out_valid && cycles < 40) begin
        check("in_ready_compute", int'(in_ready), 0);
        tick();
        cycles++;
      end
      check("first_out_latency", cycles, 12);
    end
  endtask

  task automatic collect_frame(input int stall_idx);
    logic [31:0] e;
    int wait_cyc;
    for (int n = 0; n < 8; n++) begin
      wait_cyc = 0;
      while (!out_valid && wait_cyc < 40) begin
        tick();
        wait_cyc++;
      end
      if (!out_valid) begin
        check("out_valid_timeout", 0, 1);
        return;
      end
      e = exp_q.pop_front();
      check("out_index", int'(out_index), n);
      check("out_last", int'(out_last), (n == 7) ? 1 : 0);
      check("out_real", int'($signed(out_real)), int'($signed(e[31:16])));
      check("out_imag", int'($signed(out_imag)), int'($signed(e[15:0])));
      check("in_ready_output", int'(in_ready), 0);
      if (n == stall_idx) begin
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          tick();
          check("stall_valid", int'(out_valid), 1);
          check("stall_index", int'(out_index), n);
          check("stall_real", int'($signed(out_real)), int'($signed(e[31:16])));
          check("stall_imag", int'($signed(out_imag)), int'($signed(e[15:0])));
          check("stall_last", int'(out_last), 0);
        end
        out_ready = 1'b1;
      end
      tick();
    end
    check("in_ready_after_frame", int'(in_ready), 1);
    check("out_valid_after_frame", int'(out_valid), 0);
  endtask

  task automatic push_impulse_exp();
    for (int n = 0; n < 8; n++) exp_q.push_back(cx(32, 0));
  endtask

  initial begin
    reset_dut();
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_index", int'(out_index), 0);
    check("rst_out_real", int'($signed(out_real)), 0);
    check("rst_out_imag", int'($signed(out_imag)), 0);
    check("rst_state", int'(state_dbg), int'(ST_LOAD));

    // Impulse, with a 5-cycle stall at index 3
    clear_frame();
    frame_in[0] = cx(256, 0);
    push_impulse_exp();
    send_frame(1'b0, 1'b1);
    collect_frame(3);

    // Tone on bin 2
    clear_frame();
    frame_in[2] = cx(256, 0);
    exp_q.push_back(cx(32, 0));  exp_q.push_back(cx(0, 32));
    exp_q.push_back(cx(-32, 0)); exp_q.push_back(cx(0, -32));
    exp_q.push_back(cx(32, 0));  exp_q.push_back(cx(0, 32));
    exp_q.push_back(cx(-32, 0)); exp_q.push_back(cx(0, -32));
    send_frame(1'b0, 1'b1);
    collect_frame(-1);

    // Tone on bin 1: exercises W1/W3 and floor truncation
    clear_frame();
    frame_in[1] = cx(256, 0);
    exp_q.push_back(cx(32, 0));   exp_q.push_back(cx(22, 22));
    exp_q.push_back(cx(0, 32));   exp_q.push_back(cx(-23, 22));
    exp_q.push_back(cx(-32, 0));  exp_q.push_back(cx(-23, -23));
    exp_q.push_back(cx(0, -32));  exp_q.push_back(cx(23, -23));
    send_frame(1'b0, 1'b1);
    collect_frame(-1);

    // Gapped impulse
    clear_frame();
    frame_in[0] = cx(256, 0);
    push_impulse_exp();
    send_frame(1'b1, 1'b1);
    collect_frame(-1);

    // DC frame interrupted by reset at compute cycle 6, then a clean DC frame
    for (int k = 0; k < 8; k++) frame_in[k] = cx(256, 0);
    send_frame(1'b0, 1'b0);
    for (int c = 0; c < 5; c++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_index", int'(out_index), 0);
    check("midrst_state", int'(state_dbg), int'(ST_LOAD));

    exp_q.push_back(cx(256, 0));
    for (int n = 1; n < 8; n++) exp_q.push_back(cx(0, 0));
    send_frame(1'b0, 1'b1);
    collect_frame(-1);

    check("exp_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifft8_serial.md
IFFT8_SERIAL -- requirements
Module: ifft8_serial

Interface
REQ-001 SHALL have parameter SCALE, default 1, meaning 1 = arithmetic right-shift by 1 after every stage (total 1/8), 0 = no scaling.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  input sample present.
REQ-005 SHALL have port in_ready  output  1  block accepts an input sample.
REQ-006 SHALL have ports in_real / in_imag  input  16 each  signed Q8.8 frequency-domain sample X[k], k in natural order.
REQ-007 SHALL have port out_valid  output  1  output sample present.
REQ-008 SHALL have port out_ready  input  1  downstream accepts output sample.
REQ-009 SHALL have ports out_real / out_imag  output  16 each  signed Q8.8 time-domain sample x[n].
REQ-010 SHALL have port out_index  output  3  n of the current output sample.
REQ-011 SHALL have port out_last  output  1  high with out_valid when out_index = 7.

Function
REQ-012 SHALL run a three-state FSM: LOAD -> COMPUTE -> OUTPUT -> LOAD; no frame overlap.
REQ-013 In LOAD, in_ready SHALL be 1; a sample transfers on any edge with in_valid && in_ready; a 3-bit load counter advances only on transfer, so gaps in in_valid are allowed.
REQ-014 Sample k SHALL be written to internal address bitrev3(k).
REQ-015 The edge that transfers sample 7 SHALL move the FSM to COMPUTE and clear the load counter.
REQ-016 In COMPUTE, the block SHALL perform exactly 12 radix-2 DIT butterflies, one per cycle, through one shared butterfly: stage s = 0,1,2, span 2^s, twiddle index (j mod span) * (4 / span).
REQ-017 Twiddles SHALL be conjugate (IFFT) Q8.8 constants: W0 = (256,0), W1 = (181,181), W2 = (0,256), W3 = (-181,181).
REQ-018 Complex multiply SHALL form 32-bit products, sum them, and arithmetic-shift right 8 (truncate).
REQ-019 Sum and difference SHALL be computed at 17 bits: SCALE=1 takes bits [16:1]; SCALE=0 takes bits [15:0] (two's-complement wrap, no saturation).
REQ-020 COMPUTE SHALL last exactly 12 cycles; out_valid SHALL be 1 in the cycle immediately after the 12th butterfly edge (first output 13 edges after the sample-7 transfer).
REQ-021 In OUTPUT, in_ready SHALL be 0 and out_valid SHALL be 1, presenting address n in natural order starting at n = 0.
REQ-022 The index SHALL advance on out_valid && out_ready; with out_ready low, out_real, out_imag, out_index and out_last SHALL hold stable.
REQ-023 The handshake at index 7 SHALL return the FSM to LOAD, with in_ready = 1 on the next cycle.
REQ-024 in_valid SHALL be ignored outside LOAD; out_ready SHALL be ignored outside OUTPUT.

Reset
REQ-025 rst = 0 at a clock edge SHALL force: FSM to LOAD, counters to 0, in_ready = 1, out_valid = 0, out_last = 0, out_index = 0, out_real = 0, out_imag = 0.
REQ-026 Sample memory SHALL clear to 0 on reset.
REQ-027 Reset SHALL take priority over all other events in any state; a partially loaded or computed frame is discarded.

Structure
REQ-028 Package ifft8_pkg SHALL hold: the state enumeration, data width 16, fraction bits 8, and the four conjugate twiddle constants.
REQ-029 The radix-2 butterfly (conjugate twiddle multiply, add/sub, SCALE shift) SHALL be one combinational sub-module, ifft8_bfly, instantiated exactly once.

Verification
REQ-030 Impulse, SCALE=1: X0 = (256,0), X1..X7 = 0 -> all eight outputs (32,0).
REQ-031 DC, SCALE=1: X0..X7 all (256,0) -> x0 = (256,0), x1..x7 = (0,0).
REQ-032 Tone, SCALE=1: X2 = (256,0), others 0 -> x0..x7 = (32,0), (0,32), (-32,0), (0,-32), then the same four values repeated.
REQ-033 Backpressure: out_ready low for 5 cycles while out_index = 3 -> outputs frozen and no sample lost; out_last high only at index 7.
REQ-034 Gapped input: REQ-030 stimulus with in_valid low on alternate cycles -> identical outputs; in_ready stays 0 from the sample-7 transfer until the index-7 output handshake.
REQ-035 Reset mid-COMPUTE (cycle 6 of 12) -> next cycle in_ready = 1 and out_valid = 0; a following REQ-031 frame gives correct results.
